// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared types and helpers for the AES ShiftRows engine.
//               STATE_W-bit state, byte_idx(row,col) maps a (row, column)
//               position to its byte number b(4c+r), where b0 sits in bits
//               [127:120] and b15 in bits [7:0].
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int BYTE_W  = 8;
    localparam int STATE_W = 128;

    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sr_state_e;

    function automatic int byte_idx(input int row, input int col);
        return 4 * col + row;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shiftrows_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : shiftrows_seq_if
// Description : Valid/ready bus of the ShiftRows engine.
//               Input side : in_valid, in_ready, state_in (+ inv_mode when
//                            SHIFTROWS_INV_EN is defined).
//               Output side: out_valid, out_ready, state_out, done_sr.
//               master = producer/consumer side, slave = engine side.
// Revision    : 1.0 - initial release
// ============================================================================
interface shiftrows_seq_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t state_in;
    logic   out_valid;
    logic   out_ready;
    state_t state_out;
    logic   done_sr;
`ifdef SHIFTROWS_INV_EN
    logic   inv_mode;

    modport master (
        output in_valid, state_in, out_ready, inv_mode,
        input  in_ready, out_valid, state_out, done_sr
    );
    modport slave (
        input  in_valid, state_in, out_ready, inv_mode,
        output in_ready, out_valid, state_out, done_sr
    );
`else
    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out, done_sr
    );
    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out, done_sr
    );
`endif

endinterface
`default_nettype wire

// File: rtl/aes_row_rotate.sv
`default_nettype none
// ============================================================================
// Module      : aes_row_rotate
// Description : Combinational one-column rotation of one state row.
//               Row word layout {col0, col1, col2, col3}, col0 in the MSBs.
//               i_en=0 passes the row through unchanged.
//               i_dir_right=0: column c takes column (c+1) mod 4 (left)
//               i_dir_right=1: column c takes column (c+3) mod 4 (right)
// Ports       : i_en, i_dir_right, i_row (in), o_row (out)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_row_rotate
    import aes_pkg::*;
(
    input  wire logic                i_en,
    input  wire logic                i_dir_right,
    input  wire logic [4*BYTE_W-1:0] i_row,
    output logic      [4*BYTE_W-1:0] o_row
);

    always_comb begin
        o_row = i_row;
        if (i_en) begin
            if (i_dir_right) begin
                o_row = {i_row[BYTE_W-1:0], i_row[4*BYTE_W-1:BYTE_W]};
            end else begin
                o_row = {i_row[3*BYTE_W-1:0], i_row[4*BYTE_W-1:3*BYTE_W]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shiftrows_seq.sv
`default_nettype none
// ============================================================================
// Module      : shiftrows_seq
// Description : Iterative AES ShiftRows engine. Accepts one 128-bit state in
//               IDLE, applies three one-column row-rotation steps
//               (SHIFT_PER_CYC steps per clock) and holds the result in DONE
//               until the consumer takes it. done_sr pulses once when the
//               result first becomes valid.
//               Optional feature macro SHIFTROWS_INV_EN: adds bus.inv_mode,
//               sampled at accept, selecting InvShiftRows (right rotation).
// Ports       : clk, rst (sync, active-high), bus (shiftrows_seq_if.slave)
// Parameters  : BYTE_W (must be 8), SHIFT_PER_CYC (1 or 3)
// Revision    : 1.0 - initial release
// ============================================================================
module shiftrows_seq #(
    parameter int BYTE_W        = 8,
    parameter int SHIFT_PER_CYC = 1
) (
    input wire logic       clk,
    input wire logic       rst,
    shiftrows_seq_if.slave bus
);
    import aes_pkg::*;

    localparam int         c_n_steps  = 3;
    localparam int         c_row_w    = 4 * BYTE_W;
    localparam logic [1:0] c_last_cnt = 2'(c_n_steps / SHIFT_PER_CYC - 1);

    if (BYTE_W != 8) begin : g_bad_byte_w
        $error("shiftrows_seq: BYTE_W must be 8");
    end
    if (SHIFT_PER_CYC != 1 && SHIFT_PER_CYC != 3) begin : g_bad_shift_per_cyc
        $error("shiftrows_seq: SHIFT_PER_CYC must be 1 or 3");
    end

    sr_state_e  r_fsm;
    logic [1:0] r_cnt;
    state_t     r_state;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_done;
    logic       w_inv;
    state_t     w_next;

`ifdef SHIFTROWS_INV_EN
    logic r_inv;
    assign w_inv = r_inv;
`else
    assign w_inv = 1'b0;
`endif

    // w_chain[r][0] is row r of the current state; each stage j applies one
    // rotation step. Global step number is cnt*SHIFT_PER_CYC + j and a row r
    // only moves on steps below r, so row 0 never moves and after all three
    // steps row r has moved exactly r columns.
    logic [c_row_w-1:0] w_chain [1:3][0:SHIFT_PER_CYC];

    for (genvar r = 1; r < 4; r++) begin : g_row
        assign w_chain[r][0] = {
            r_state[STATE_W-1-BYTE_W*byte_idx(r, 0) -: BYTE_W],
            r_state[STATE_W-1-BYTE_W*byte_idx(r, 1) -: BYTE_W],
            r_state[STATE_W-1-BYTE_W*byte_idx(r, 2) -: BYTE_W],
            r_state[STATE_W-1-BYTE_W*byte_idx(r, 3) -: BYTE_W]
        };
        for (genvar j = 0; j < SHIFT_PER_CYC; j++) begin : g_stage
            logic w_en;
            assign w_en = (({2'b00, r_cnt} * 4'(SHIFT_PER_CYC)) + 4'(j)) < 4'(r);
            aes_row_rotate u_rot (
                .i_en        (w_en),
                .i_dir_right (w_inv),
                .i_row       (w_chain[r][j]),
                .o_row       (w_chain[r][j+1])
            );
        end
    end

    // Reassemble the state: row 0 copied, rows 1..3 from the last stage.
    always_comb begin
        w_next = r_state;
        for (int r = 1; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_next[STATE_W-1-BYTE_W*byte_idx(r, c) -: BYTE_W] =
                    w_chain[r][SHIFT_PER_CYC][c_row_w-1-BYTE_W*c -: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_cnt       <= 2'd0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
`ifdef SHIFTROWS_INV_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_state    <= bus.state_in;
                        r_cnt      <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_fsm      <= SHIFT;
`ifdef SHIFTROWS_INV_EN
                        r_inv      <= bus.inv_mode;
`endif
                    end
                end
                SHIFT: begin
                    r_state <= w_next;
                    if (r_cnt == c_last_cnt) begin
                        r_cnt       <= 2'd0;
                        r_fsm       <= DONE;
                        r_out_valid <= 1'b1;
                        r_done      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_fsm       <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.state_out = r_state;
    assign bus.done_sr   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shiftrows_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_shiftrows_seq
// Description : Scoreboard bench for shiftrows_seq. Drives directed vectors
//               into a SHIFT_PER_CYC=1 and a SHIFT_PER_CYC=3 instance; the
//               expected state and arrival cycle are queued at issue and
//               popped by per-instance monitors when out_valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_shiftrows_seq;
    import aes_pkg::*;

    localparam state_t c_fips_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam state_t c_fips_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam state_t c_seq_in   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam state_t c_seq_out  = 128'h00050a0f04090e03080d02070c01060b;
`ifdef SHIFTROWS_INV_EN
    localparam state_t c_seq_inv  = 128'h000d0a0704010e0b0805020f0c090603;
`endif

    typedef struct {
        state_t data;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shiftrows_seq_if bus1 ();
    shiftrows_seq_if bus3 ();

    shiftrows_seq #(.BYTE_W(8), .SHIFT_PER_CYC(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );
    shiftrows_seq #(.BYTE_W(8), .SHIFT_PER_CYC(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- monitors ----------------
    logic   r_pv1 = 1'b0;
    logic   r_pv3 = 1'b0;
    state_t r_po1 = '0;
    state_t r_po3 = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            r_pv1 <= 1'b0;
        end else begin
            if (bus1.out_valid && !r_pv1) begin
                if (q1.size() == 0) begin
                    check("dut1_unexpected_out", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("dut1_data", bus1.state_out, e.data);
                    check("dut1_latency", cyc, e.cyc);
                    check("dut1_done_rise", bus1.done_sr, 1);
                end
            end else if (bus1.out_valid) begin
                check("dut1_hold_data", bus1.state_out, r_po1);
                check("dut1_done_once", bus1.done_sr, 0);
            end else begin
                check("dut1_done_idle", bus1.done_sr, 0);
            end
            r_pv1 <= bus1.out_valid;
            r_po1 <= bus1.state_out;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            r_pv3 <= 1'b0;
        end else begin
            if (bus3.out_valid && !r_pv3) begin
                if (q3.size() == 0) begin
                    check("dut3_unexpected_out", 1, 0);
                end else begin
                    e = q3.pop_front();
                    check("dut3_data", bus3.state_out, e.data);
                    check("dut3_latency", cyc, e.cyc);
                    check("dut3_done_rise", bus3.done_sr, 1);
                end
            end else if (bus3.out_valid) begin
                check("dut3_done_once", bus3.done_sr, 0);
            end
            r_pv3 <= bus3.out_valid;
            r_po3 <= bus3.state_out;
        end
    end

    // ---------------- drivers (called #1 after a posedge) ----------------
    task automatic send1(input state_t d, input bit push, input state_t exp);
        int n = 0;
        while (!bus1.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bus1.in_ready) check("dut1_in_ready_timeout", 0, 1);
        bus1.in_valid = 1'b1;
        bus1.state_in = d;
        if (push) q1.push_back('{exp, cyc + 1 + 3});
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic send3(input state_t d, input state_t exp);
        int n = 0;
        while (!bus3.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bus3.in_ready) check("dut3_in_ready_timeout", 0, 1);
        bus3.in_valid = 1'b1;
        bus3.state_in = d;
        q3.push_back('{exp, cyc + 1 + 1});
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
    endtask

    initial begin
        int n;
        bus1.in_valid = 1'b0; bus1.state_in = '0; bus1.out_ready = 1'b1;
        bus3.in_valid = 1'b0; bus3.state_in = '0; bus3.out_ready = 1'b1;
`ifdef SHIFTROWS_INV_EN
        bus1.inv_mode = 1'b0;
        bus3.inv_mode = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus1.in_ready, 1);
        check("rst_out_valid", bus1.out_valid, 0);
        check("rst_state_out", bus1.state_out, 0);
        check("rst_done_sr", bus1.done_sr, 0);
        check("rst3_in_ready", bus3.in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 round 1 vector and the byte-index vector
        send1(c_fips_in, 1'b1, c_fips_out);
        send1(c_seq_in, 1'b1, c_seq_out);
        send3(c_seq_in, c_seq_out);
        send3(c_fips_in, c_fips_out);

        // back-pressure: hold out_ready low for 10 cycles once valid
        bus1.out_ready = 1'b0;
        send1(c_seq_in, 1'b1, c_seq_out);
        n = 0;
        while (!bus1.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("bp_out_valid_seen", bus1.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready_low", bus1.in_ready, 0);
            check("bp_out_valid_held", bus1.out_valid, 1);
            check("bp_state_out", bus1.state_out, c_seq_out);
        end
        bus1.out_ready = 1'b1;

        // in_valid with all-ones during SHIFT must be ignored
        n = 0;
        while (!bus1.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        bus1.in_valid = 1'b1;
        bus1.state_in = c_fips_in;
        q1.push_back('{c_fips_out, cyc + 1 + 3});
        @(posedge clk); #1;
        bus1.state_in = '1;
        repeat (2) begin
            @(posedge clk); #1;
            check("shift_in_ready_low", bus1.in_ready, 0);
        end
        bus1.in_valid = 1'b0;

        // reset during the second SHIFT cycle discards the operation
        send1(c_fips_in, 1'b0, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", bus1.in_ready, 1);
        check("midrst_out_valid", bus1.out_valid, 0);
        check("midrst_state_out", bus1.state_out, 0);
        repeat (5) @(posedge clk);
        #1;

`ifdef SHIFTROWS_INV_EN
        bus1.inv_mode = 1'b1;
        send1(c_seq_in, 1'b1, c_seq_inv);
        bus1.inv_mode = 1'b0;
        send1(c_fips_in, 1'b1, c_fips_out);
        bus1.inv_mode = 1'b1;
        send1(c_fips_out, 1'b1, c_fips_in);
        bus1.inv_mode = 1'b0;
        bus3.inv_mode = 1'b1;
        send3(c_seq_in, c_seq_inv);
        bus3.inv_mode = 1'b0;
`endif

        n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("drain_q1_empty", q1.size(), 0);
        check("drain_q3_empty", q3.size(), 0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
